// File: rtl/health_sync_pkg.sv
// Shared constants and helpers for the health-indicator input conditioning blocks.
package health_sync_pkg;

    localparam int DEFAULT_STAGES   = 2;
    localparam int DEFAULT_DEBOUNCE = 16;

    // Ceiling log2; clog2(1) = 0. Callers size counters with clog2(N+1).
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One input channel: N-flop synchronizer, debounce counter, accepted level and
// registered rise/fall pulses that line up with the accepted level changing.
module sync_debounce_channel
    import health_sync_pkg::*;
#(
    parameter int   STAGES          = DEFAULT_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic db_bypass,
    output logic sync_out,
    output logic stable_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int            CW       = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          sync_lvl;

    assign sync_lvl = sync_q[STAGES-1];

    // Synchronizer shift chain; bit 0 is the metastability-exposed flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    // Debounce decision: a new level is accepted only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive edges. Any
    // matching cycle restarts the count, and bypass keeps it parked at zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (db_bypass) begin
            stable_d = sync_lvl;
        end else if (sync_lvl != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_lvl;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Pulses come from the same next-state compare so they register on the
        // exact edge the accepted level changes.
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    // Counter, accepted level and edge pulse registers; reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sync_out   = sync_lvl;
    assign stable_out = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/sync_debounce_bank.sv
// Multi-channel synchronizer + debounce bank feeding the health FSM and LED logic.
module sync_debounce_bank
    import health_sync_pkg::*;
#(
    parameter int   CHANNELS        = 4,
    parameter int   STAGES          = DEFAULT_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] din,
    input  logic [CHANNELS-1:0] db_bypass,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] stable_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    // Independent per-channel conditioners.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sync_debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .din        (din[g]),
            .db_bypass  (db_bypass[g]),
            .sync_out   (sync_out[g]),
            .stable_out (stable_out[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g])
        );
    end

    // Summary strobe: simultaneous events on several channels share one cycle.
    always_comb begin
        any_change = |(rise_pulse | fall_pulse);
    end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Bench for sync_debounce_bank: timed expectations are queued when stimulus is
// applied and compared on the falling edge after the edge they are due on.
module tb_sync_debounce_bank;

    localparam int CH = 4;

    localparam int S_SYNC   = 0;
    localparam int S_STABLE = 1;
    localparam int S_RISE   = 2;
    localparam int S_FALL   = 3;
    localparam int S_ANY    = 4;

    logic          clk;
    logic          reset;
    logic [CH-1:0] din;
    logic [CH-1:0] db_bypass;
    logic [CH-1:0] sync_out;
    logic [CH-1:0] stable_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic          any_change;

    sync_debounce_bank #(
        .CHANNELS        (CH),
        .STAGES          (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .db_bypass  (db_bypass),
        .sync_out   (sync_out),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    at;
        string tag;
        int    sel;
        int    ch;
        logic  v;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   k;
    int   r;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @edge %0d got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic observe(input int sel, input int ch);
        case (sel)
            S_SYNC:   return sync_out[ch];
            S_STABLE: return stable_out[ch];
            S_RISE:   return rise_pulse[ch];
            S_FALL:   return fall_pulse[ch];
            default:  return any_change;
        endcase
    endfunction

    task automatic expect_at(input int at, input string tag, input int sel, input int ch, input logic v);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.sel = sel;
        e.ch  = ch;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    // Advance n rising edges; after each, compare every entry due on that edge.
    task automatic step(input int n);
        exp_t keep[$];
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            keep = {};
            foreach (sb_q[j]) begin
                if (sb_q[j].at <= cyc) begin
                    check_eq($sformatf("%s[%0d]", sb_q[j].tag, sb_q[j].ch),
                             {31'b0, observe(sb_q[j].sel, sb_q[j].ch)},
                             {31'b0, sb_q[j].v});
                end else begin
                    keep.push_back(sb_q[j]);
                end
            end
            sb_q = keep;
        end
    endtask

    initial begin
        reset     = 1'b1;
        din       = 4'hF;
        db_bypass = 4'h0;

        // Reset held 3 edges with all inputs high: nothing may propagate.
        for (int e = 1; e <= 3; e++) begin
            for (int c = 0; c < CH; c++) begin
                expect_at(e, "rst_sync", S_SYNC, c, 1'b0);
                expect_at(e, "rst_stable", S_STABLE, c, 1'b0);
                expect_at(e, "rst_rise", S_RISE, c, 1'b0);
                expect_at(e, "rst_fall", S_FALL, c, 1'b0);
            end
            expect_at(e, "rst_any", S_ANY, 0, 1'b0);
        end
        step(3);
        reset = 1'b0;
        din   = 4'h0;
        step(3);

        // Debounced rise on ch0.
        k = cyc + 1;
        din[0] = 1'b1;
        expect_at(k,     "t2_sync_k", S_SYNC, 0, 1'b0);
        expect_at(k + 1, "t2_sync", S_SYNC, 0, 1'b1);
        expect_at(k + 4, "t2_stable_early", S_STABLE, 0, 1'b0);
        expect_at(k + 4, "t2_rise_early", S_RISE, 0, 1'b0);
        expect_at(k + 5, "t2_stable", S_STABLE, 0, 1'b1);
        expect_at(k + 5, "t2_rise", S_RISE, 0, 1'b1);
        expect_at(k + 5, "t2_any", S_ANY, 0, 1'b1);
        expect_at(k + 6, "t2_rise_end", S_RISE, 0, 1'b0);
        expect_at(k + 6, "t2_stable_hold", S_STABLE, 0, 1'b1);
        expect_at(k + 6, "t2_any_end", S_ANY, 0, 1'b0);
        step(8);

        // ch1 high for one cycle less than the debounce window: rejected.
        k = cyc + 1;
        din[1] = 1'b1;
        for (int e = 1; e <= 3; e++) expect_at(k + e, "t3_sync_hi", S_SYNC, 1, 1'b1);
        expect_at(k + 4, "t3_sync_lo", S_SYNC, 1, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            expect_at(k + e, "t3_stable", S_STABLE, 1, 1'b0);
            expect_at(k + e, "t3_rise", S_RISE, 1, 1'b0);
            expect_at(k + e, "t3_any", S_ANY, 0, 1'b0);
        end
        step(3);
        din[1] = 1'b0;
        step(7);

        // Bypass on ch2: level follows sync_out with no debounce delay.
        k = cyc + 1;
        db_bypass[2] = 1'b1;
        din[2]       = 1'b1;
        expect_at(k + 1, "t4_sync", S_SYNC, 2, 1'b1);
        expect_at(k + 1, "t4_stable_early", S_STABLE, 2, 1'b0);
        expect_at(k + 2, "t4_stable", S_STABLE, 2, 1'b1);
        expect_at(k + 2, "t4_rise", S_RISE, 2, 1'b1);
        expect_at(k + 3, "t4_rise_end", S_RISE, 2, 1'b0);
        step(5);
        db_bypass[2] = 1'b0;
        expect_at(cyc + 1, "t4_unbyp_rise", S_RISE, 2, 1'b0);
        expect_at(cyc + 2, "t4_unbyp_stable", S_STABLE, 2, 1'b1);
        step(2);

        // Simultaneous fall on ch0 and rise on ch3.
        k = cyc + 1;
        din[0] = 1'b0;
        din[3] = 1'b1;
        expect_at(k + 4, "t5_any_early", S_ANY, 0, 1'b0);
        expect_at(k + 4, "t5_stable0_early", S_STABLE, 0, 1'b1);
        expect_at(k + 4, "t5_stable3_early", S_STABLE, 3, 1'b0);
        expect_at(k + 5, "t5_fall", S_FALL, 0, 1'b1);
        expect_at(k + 5, "t5_rise", S_RISE, 3, 1'b1);
        expect_at(k + 5, "t5_rise0", S_RISE, 0, 1'b0);
        expect_at(k + 5, "t5_fall3", S_FALL, 3, 1'b0);
        expect_at(k + 5, "t5_any", S_ANY, 0, 1'b1);
        expect_at(k + 5, "t5_stable0", S_STABLE, 0, 1'b0);
        expect_at(k + 5, "t5_stable3", S_STABLE, 3, 1'b1);
        expect_at(k + 6, "t5_fall_end", S_FALL, 0, 1'b0);
        expect_at(k + 6, "t5_rise_end", S_RISE, 3, 1'b0);
        expect_at(k + 6, "t5_any_end", S_ANY, 0, 1'b0);
        step(8);

        // Reset mid-debounce on ch0; ch2/ch3 drop to 0 without pulses.
        k = cyc + 1;
        din[0] = 1'b1;
        expect_at(k + 3, "t6_stable_pre", S_STABLE, 0, 1'b0);
        step(4);
        reset = 1'b1;
        din   = 4'b0001;
        for (int c = 0; c < CH; c++) begin
            expect_at(k + 4, "t6_rst_sync", S_SYNC, c, 1'b0);
            expect_at(k + 4, "t6_rst_stable", S_STABLE, c, 1'b0);
            expect_at(k + 4, "t6_rst_rise", S_RISE, c, 1'b0);
            expect_at(k + 4, "t6_rst_fall", S_FALL, c, 1'b0);
        end
        expect_at(k + 4, "t6_rst_any", S_ANY, 0, 1'b0);
        step(1);
        reset = 1'b0;
        r = cyc + 1;
        expect_at(r,     "t6_sync_r", S_SYNC, 0, 1'b0);
        expect_at(r + 1, "t6_sync", S_SYNC, 0, 1'b1);
        for (int e = 1; e <= 4; e++) begin
            expect_at(r + e, "t6_stable_wait", S_STABLE, 0, 1'b0);
            expect_at(r + e, "t6_any_wait", S_ANY, 0, 1'b0);
        end
        expect_at(r + 5, "t6_stable", S_STABLE, 0, 1'b1);
        expect_at(r + 5, "t6_rise", S_RISE, 0, 1'b1);
        expect_at(r + 5, "t6_any", S_ANY, 0, 1'b1);
        expect_at(r + 6, "t6_rise_end", S_RISE, 0, 1'b0);
        step(8);

        check_eq("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
